dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the 64-word data memory. It shares the memory between the CPU MEM stage (port 0) and the debug/loader port (port 1) with round-robin arbitration. It inserts a programmable number of wait cycles per access and rejects misaligned or out-of-range addresses without touching memory. Each requester sees a request/ready handshake, and the CPU derives its pipeline freeze from that handshake.

## Interface
- WAIT_CYCLES, 1: extra access cycles per transaction; legal range 0..15.
- DEPTH, 64: memory depth in 32-bit words; the word index is addr >> 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req, dbg_req  in  1 each  transaction request; held until the matching ready.
- cpu_we, dbg_we  in  1 each  1 = write, 0 = read.
- cpu_addr, dbg_addr  in  32 each  byte address.
- cpu_wdata, dbg_wdata  in  32 each  write data.
- cpu_ready, dbg_ready  out  1 each  one-cycle completion pulse.
- cpu_err, dbg_err  out  1 each  valid with ready; 1 = rejected access.
- cpu_rdata, dbg_rdata  out  32 each  read data; valid only while the matching ready is high.
- mem_read, mem_write  out  1 each  memory strobes.
- mem_address, mem_data  out  32 each  memory byte address and write data.
- mem_result  in  32  combinational memory read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE
  - If any req is high, grant one port and latch its we, addr and wdata into internal registers.
  - With both requests high, grant the port flagged by the priority bit. The priority bit then points to the other port.
  - With a single request, grant that port and set the priority bit to the other port.
  - Reset value of the priority bit selects port 0.
- Validity check, done in IDLE on the granted address: addr[1:0] != 0, or (addr >> 2) >= DEPTH, makes the access invalid.
  - Invalid access: set err and go directly to RESP. No memory strobe is driven.
  - Valid access: load the wait counter with WAIT_CYCLES and go to ACCESS.
- ACCESS
  - Drive mem_address and mem_data from the latched registers.
  - Reads: mem_read is high for every ACCESS cycle.
  - Writes: mem_write is high only in the final ACCESS cycle (counter == 0), so each transaction writes exactly once. mem_read stays low for writes.
  - Counter != 0: decrement and stay in ACCESS.
  - Counter == 0: for reads, capture mem_result into the rdata register; go to RESP.
- RESP
  - Pulse the granted port's ready for one cycle. That port's rdata shows the captured value; it is 0 for writes and for errors. err is driven as decided in IDLE.
  - Return to IDLE.
- The ungranted port's ready, err and rdata stay 0 at all times.
- In IDLE and RESP, mem_address and mem_data are 0 and both strobes are low.
- Handshake rules:
  - A requester must keep req, we, addr and wdata stable until its ready.
  - Once latched, a transaction completes and ready pulses even if req drops early.
  - req still high in the cycle after ready is treated as a new request.
- Reset mid-operation
  - rst forces IDLE immediately (asynchronously). The transaction is dropped with no ready pulse.
  - All outputs go to 0 immediately, including a mem_write that is in flight.

## Timing
- Reset values: every output is 0; state IDLE; counter 0; priority bit selects port 0.
- Valid access, request sampled in IDLE at edge N:
  - ACCESS occupies cycles N+1 .. N+1+WAIT_CYCLES.
  - RESP and ready occur in cycle N+2+WAIT_CYCLES.
- Invalid access: ready and err occur in cycle N+1.
- Throughput: one transaction per WAIT_CYCLES+3 cycles, because IDLE is revisited between transactions.
- WAIT_CYCLES = 0: a single ACCESS cycle. Reads assert mem_read for one cycle; writes assert mem_write in that same cycle.
- CPU freeze is cpu_req & ~cpu_ready, formed outside this block.

## Test plan
- Write, WAIT_CYCLES=2: cpu write of 0xDEADBEEF to 0x10, request at edge 0.
  - Required: mem_read stays low, mem_write is high only in cycle 3 with mem_address 0x10, cpu_ready is high in cycle 4 with cpu_err=0.
  - Follow-up dbg read of 0x10 returns dbg_rdata=0xDEADBEEF.
- Contention: after reset, cpu_req and dbg_req are held continuously high.
  - Required grant order: cpu, dbg, cpu, dbg.
  - Required: ready pulses alternate ports, one every WAIT_CYCLES+3 cycles, and no port waits for more than one foreign transaction.
- Address checks: dbg read at 0x13, then cpu write at 0x100 with DEPTH=64.
  - Required: each gets ready plus err in the next cycle, rdata=0, mem_read and mem_write never asserted, memory contents unchanged.
- Reset mid-op: assert rst during the second ACCESS cycle of a cpu write.
  - Required: mem_write is never asserted, cpu_ready never pulses, and busy drops asynchronously.
  - After release, a read of the target address returns 0.
- Zero wait, WAIT_CYCLES=0: back-to-back cpu reads of 0x0 and 0x4 with req held high.
  - Required: ready for the first read at cycle 2, for the second at cycle 5.
  - Required: mem_read is high exactly one cycle per read, and rdata matches preloaded values.
- Early drop: dbg_req is high for only one cycle, with a read of 0x8.
  - Required: the transaction still completes and dbg_ready pulses at cycle 2+WAIT_CYCLES.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin CPU/debug arbiter and wait-state sequencer for the
//            64-word data memory, with alignment and range rejection.
// Revision : 1.0 - initial release
// ============================================================================

module dmem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_result,
  output logic        busy
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_resp   = 2'd2;
  localparam logic [3:0] c_wait      = 4'(WAIT_CYCLES);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_prio;
  logic        r_gnt;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_any;
  logic        w_gnt;
  logic [31:0] w_gnt_addr;
  logic        w_invalid;
  logic        w_access;
  logic        w_resp;

  // Port select: 0 = cpu, 1 = dbg. The priority bit only matters on contention.
  always_comb begin
    w_any = cpu_req | dbg_req;
    if (cpu_req && dbg_req) begin
      w_gnt = r_prio;
    end else begin
      w_gnt = dbg_req;
    end
    w_gnt_addr = w_gnt ? dbg_addr : cpu_addr;
    w_invalid  = (w_gnt_addr[1:0] != 2'b00) || ((w_gnt_addr >> 2) >= DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_cnt   <= 4'd0;
      r_prio  <= 1'b0;
      r_gnt   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_prio  <= ~w_gnt;
            r_we    <= w_gnt ? dbg_we : cpu_we;
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt ? dbg_wdata : cpu_wdata;
            r_rdata <= 32'd0;
            r_err   <= w_invalid;
            if (w_invalid) begin
              r_cnt   <= 4'd0;
              r_state <= c_st_resp;
            end else begin
              r_cnt   <= c_wait;
              r_state <= c_st_access;
            end
          end
        end
        c_st_access: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_we) begin
              r_rdata <= mem_result;
            end
            r_state <= c_st_resp;
          end
        end
        c_st_resp: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  always_comb begin
    w_access    = (r_state == c_st_access);
    w_resp      = (r_state == c_st_resp);
    mem_read    = w_access & ~r_we;
    mem_write   = w_access & r_we & (r_cnt == 4'd0);
    mem_address = w_access ? r_addr  : 32'd0;
    mem_data    = w_access ? r_wdata : 32'd0;
    cpu_ready   = w_resp & ~r_gnt;
    dbg_ready   = w_resp & r_gnt;
    cpu_err     = cpu_ready & r_err;
    dbg_err     = dbg_ready & r_err;
    cpu_rdata   = cpu_ready ? r_rdata : 32'd0;
    dbg_rdata   = dbg_ready ? r_rdata : 32'd0;
    busy        = (r_state != c_st_idle);
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter (WAIT_CYCLES 2 and 0).
// Revision : 1.0 - initial release
// ============================================================================

module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance "a": WAIT_CYCLES = 2
  logic        a_cpu_req = 1'b0, a_cpu_we = 1'b0, a_dbg_req = 1'b0, a_dbg_we = 1'b0;
  logic [31:0] a_cpu_addr = '0, a_cpu_wdata = '0, a_dbg_addr = '0, a_dbg_wdata = '0;
  logic        a_cpu_ready, a_cpu_err, a_dbg_ready, a_dbg_err, a_mem_read, a_mem_write, a_busy;
  logic [31:0] a_cpu_rdata, a_dbg_rdata, a_mem_address, a_mem_data, a_mem_result;
  logic [31:0] a_mem [64] = '{2: 32'h0808_0808, default: 32'h0};

  assign a_mem_result = a_mem[a_mem_address[7:2]];
  always @(posedge clk) if (a_mem_write) a_mem[a_mem_address[7:2]] <= a_mem_data;

  // Instance "z": WAIT_CYCLES = 0, cpu port only exercised
  logic        z_cpu_req = 1'b0, z_cpu_we = 1'b0, z_dbg_req = 1'b0, z_dbg_we = 1'b0;
  logic [31:0] z_cpu_addr = '0, z_cpu_wdata = '0, z_dbg_addr = '0, z_dbg_wdata = '0;
  logic        z_cpu_ready, z_cpu_err, z_dbg_ready, z_dbg_err, z_mem_read, z_mem_write, z_busy;
  logic [31:0] z_cpu_rdata, z_dbg_rdata, z_mem_address, z_mem_data, z_mem_result;
  logic [31:0] z_mem [64] = '{0: 32'hA5A5_0001, 1: 32'h5A5A_0002, default: 32'h0};

  assign z_mem_result = z_mem[z_mem_address[7:2]];
  always @(posedge clk) if (z_mem_write) z_mem[z_mem_address[7:2]] <= z_mem_data;

  dmem_arbiter #(.WAIT_CYCLES(2), .DEPTH(64)) u_dut_w2 (
    .clk(clk), .rst(rst),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ready(a_cpu_ready), .cpu_err(a_cpu_err), .cpu_rdata(a_cpu_rdata),
    .dbg_req(a_dbg_req), .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
    .dbg_ready(a_dbg_ready), .dbg_err(a_dbg_err), .dbg_rdata(a_dbg_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_address(a_mem_address),
    .mem_data(a_mem_data), .mem_result(a_mem_result), .busy(a_busy)
  );

  dmem_arbiter #(.WAIT_CYCLES(0), .DEPTH(64)) u_dut_w0 (
    .clk(clk), .rst(rst),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_ready(z_cpu_ready), .cpu_err(z_cpu_err), .cpu_rdata(z_cpu_rdata),
    .dbg_req(z_dbg_req), .dbg_we(z_dbg_we), .dbg_addr(z_dbg_addr), .dbg_wdata(z_dbg_wdata),
    .dbg_ready(z_dbg_ready), .dbg_err(z_dbg_err), .dbg_rdata(z_dbg_rdata),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .mem_address(z_mem_address),
    .mem_data(z_mem_data), .mem_result(z_mem_result), .busy(z_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({a_busy, a_cpu_ready, a_dbg_ready, a_cpu_err, a_dbg_err, a_mem_read, a_mem_write} !== 7'b0) begin
      n_bad++; $display("FAIL reset_a_flags: got %b expected 0000000",
        {a_busy, a_cpu_ready, a_dbg_ready, a_cpu_err, a_dbg_err, a_mem_read, a_mem_write});
    end
    n_cmp++;
    if ((a_mem_address | a_mem_data | a_cpu_rdata | a_dbg_rdata) !== 32'h0) begin
      n_bad++; $display("FAIL reset_a_buses: got %h expected 00000000",
        a_mem_address | a_mem_data | a_cpu_rdata | a_dbg_rdata);
    end
    n_cmp++;
    if ({z_busy, z_cpu_ready, z_mem_read, z_mem_write} !== 4'b0) begin
      n_bad++; $display("FAIL reset_z_flags: got %b expected 0000",
        {z_busy, z_cpu_ready, z_mem_read, z_mem_write});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (a_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_after_release: busy got %b expected 0", a_busy);
    end
  endtask

  task automatic test_write();
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 32'h10; a_cpu_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_cmp++;
      if (a_mem_read !== 1'b0) begin
        n_bad++; $display("FAIL write_mem_read c%0d: got %b expected 0", c, a_mem_read);
      end
      n_cmp++;
      if (a_mem_write !== (c == 3)) begin
        n_bad++; $display("FAIL write_mem_write c%0d: got %b expected %b", c, a_mem_write, (c == 3));
      end
      if (c == 3) begin
        n_cmp++;
        if (a_mem_address !== 32'h10 || a_mem_data !== 32'hDEAD_BEEF) begin
          n_bad++; $display("FAIL write_bus: got addr %h data %h expected 00000010 deadbeef",
            a_mem_address, a_mem_data);
        end
      end
      n_cmp++;
      if (a_cpu_ready !== (c == 4)) begin
        n_bad++; $display("FAIL write_ready c%0d: got %b expected %b", c, a_cpu_ready, (c == 4));
      end
      if (c == 4) begin
        n_cmp++;
        if (a_cpu_err !== 1'b0 || a_cpu_rdata !== 32'h0) begin
          n_bad++; $display("FAIL write_resp: got err %b rdata %h expected 0 00000000", a_cpu_err, a_cpu_rdata);
        end
        a_cpu_req = 1'b0;
      end
    end
    n_cmp++;
    if (a_mem[4] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL write_mem_content: got %h expected deadbeef", a_mem[4]);
    end
    a_dbg_req = 1'b1; a_dbg_we = 1'b0; a_dbg_addr = 32'h10;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_cmp++;
      if (a_dbg_ready !== (c == 4)) begin
        n_bad++; $display("FAIL readback_ready c%0d: got %b expected %b", c, a_dbg_ready, (c == 4));
      end
      if (c == 4) begin
        n_cmp++;
        if (a_dbg_rdata !== 32'hDEAD_BEEF) begin
          n_bad++; $display("FAIL readback_data: got %h expected deadbeef", a_dbg_rdata);
        end
        a_dbg_req = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h10;
    a_dbg_req = 1'b1; a_dbg_we = 1'b0; a_dbg_addr = 32'h8;
    for (int c = 1; c <= 21; c++) begin
      tick();
      n_cmp++;
      if (a_cpu_ready !== (c == 4 || c == 14)) begin
        n_bad++; $display("FAIL contention_cpu_ready c%0d: got %b expected %b", c, a_cpu_ready, (c == 4 || c == 14));
      end
      n_cmp++;
      if (a_dbg_ready !== (c == 9 || c == 19)) begin
        n_bad++; $display("FAIL contention_dbg_ready c%0d: got %b expected %b", c, a_dbg_ready, (c == 9 || c == 19));
      end
      if (c == 4 || c == 14) begin
        n_cmp++;
        if (a_cpu_rdata !== 32'hDEAD_BEEF || a_dbg_rdata !== 32'h0) begin
          n_bad++; $display("FAIL contention_cpu_data c%0d: got cpu %h dbg %h expected deadbeef 00000000",
            c, a_cpu_rdata, a_dbg_rdata);
        end
      end
      if (c == 9 || c == 19) begin
        n_cmp++;
        if (a_dbg_rdata !== 32'h0808_0808 || a_cpu_rdata !== 32'h0) begin
          n_bad++; $display("FAIL contention_dbg_data c%0d: got dbg %h cpu %h expected 08080808 00000000",
            c, a_dbg_rdata, a_cpu_rdata);
        end
      end
      if (c == 19) begin
        a_cpu_req = 1'b0;
        a_dbg_req = 1'b0;
      end
    end
  endtask

  task automatic test_addr_checks();
    a_dbg_req = 1'b1; a_dbg_we = 1'b0; a_dbg_addr = 32'h13;
    tick();
    n_cmp++;
    if ({a_dbg_ready, a_dbg_err, a_cpu_ready, a_mem_read, a_mem_write} !== 5'b11000 || a_dbg_rdata !== 32'h0) begin
      n_bad++; $display("FAIL misaligned: got rdy/err/cpu/rd/wr %b rdata %h expected 11000 00000000",
        {a_dbg_ready, a_dbg_err, a_cpu_ready, a_mem_read, a_mem_write}, a_dbg_rdata);
    end
    a_dbg_req = 1'b0;
    tick();
    n_cmp++;
    if (a_dbg_ready !== 1'b0 || a_busy !== 1'b0) begin
      n_bad++; $display("FAIL misaligned_after: got ready %b busy %b expected 0 0", a_dbg_ready, a_busy);
    end
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 32'h100; a_cpu_wdata = 32'h1234_5678;
    tick();
    n_cmp++;
    if ({a_cpu_ready, a_cpu_err, a_dbg_ready, a_dbg_err, a_mem_read, a_mem_write} !== 6'b110000 ||
        a_cpu_rdata !== 32'h0) begin
      n_bad++; $display("FAIL out_of_range: got flags %b rdata %h expected 110000 00000000",
        {a_cpu_ready, a_cpu_err, a_dbg_ready, a_dbg_err, a_mem_read, a_mem_write}, a_cpu_rdata);
    end
    a_cpu_req = 1'b0;
    tick();
    n_cmp++;
    if (a_mem[0] !== 32'h0 || a_mem_write !== 1'b0) begin
      n_bad++; $display("FAIL out_of_range_mem: got mem0 %h wr %b expected 00000000 0", a_mem[0], a_mem_write);
    end
  endtask

  task automatic test_reset_midop();
    a_cpu_req = 1'b1; a_cpu_we = 1'b1; a_cpu_addr = 32'h20; a_cpu_wdata = 32'hCAFE_F00D;
    tick();
    tick();
    n_cmp++;
    if (a_busy !== 1'b1 || a_mem_write !== 1'b0) begin
      n_bad++; $display("FAIL midop_before: got busy %b wr %b expected 1 0", a_busy, a_mem_write);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_busy, a_mem_write, a_cpu_ready} !== 3'b000 || a_mem_address !== 32'h0) begin
      n_bad++; $display("FAIL midop_async: got busy/wr/rdy %b addr %h expected 000 00000000",
        {a_busy, a_mem_write, a_cpu_ready}, a_mem_address);
    end
    a_cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++;
      if (a_cpu_ready !== 1'b0 || a_mem_write !== 1'b0) begin
        n_bad++; $display("FAIL midop_quiet c%0d: got ready %b wr %b expected 0 0", c, a_cpu_ready, a_mem_write);
      end
    end
    a_dbg_req = 1'b1; a_dbg_we = 1'b0; a_dbg_addr = 32'h20;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_cmp++;
      if (a_dbg_ready !== (c == 4)) begin
        n_bad++; $display("FAIL midop_readback_ready c%0d: got %b expected %b", c, a_dbg_ready, (c == 4));
      end
      if (c == 4) begin
        n_cmp++;
        if (a_dbg_rdata !== 32'h0 || a_dbg_err !== 1'b0 || a_mem[8] !== 32'h0) begin
          n_bad++; $display("FAIL midop_readback: got rdata %h err %b mem %h expected 00000000 0 00000000",
            a_dbg_rdata, a_dbg_err, a_mem[8]);
        end
        a_dbg_req = 1'b0;
      end
    end
  endtask

  task automatic test_zero_wait();
    z_cpu_req = 1'b1; z_cpu_we = 1'b0; z_cpu_addr = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_cmp++;
      if (z_mem_read !== (c == 1 || c == 4)) begin
        n_bad++; $display("FAIL zero_wait_read c%0d: got %b expected %b", c, z_mem_read, (c == 1 || c == 4));
      end
      n_cmp++;
      if (z_cpu_ready !== (c == 2 || c == 5)) begin
        n_bad++; $display("FAIL zero_wait_ready c%0d: got %b expected %b", c, z_cpu_ready, (c == 2 || c == 5));
      end
      if (c == 2) begin
        n_cmp++;
        if (z_cpu_rdata !== 32'hA5A5_0001) begin
          n_bad++; $display("FAIL zero_wait_data0: got %h expected a5a50001", z_cpu_rdata);
        end
        z_cpu_addr = 32'h4;
      end
      if (c == 5) begin
        n_cmp++;
        if (z_cpu_rdata !== 32'h5A5A_0002) begin
          n_bad++; $display("FAIL zero_wait_data1: got %h expected 5a5a0002", z_cpu_rdata);
        end
        z_cpu_req = 1'b0;
      end
    end
  endtask

  task automatic test_early_drop();
    a_dbg_req = 1'b1; a_dbg_we = 1'b0; a_dbg_addr = 32'h8;
    for (int c = 1; c <= 5; c++) begin
      tick();
      a_dbg_req = 1'b0;
      n_cmp++;
      if (a_dbg_ready !== (c == 4)) begin
        n_bad++; $display("FAIL early_drop_ready c%0d: got %b expected %b", c, a_dbg_ready, (c == 4));
      end
      if (c == 4) begin
        n_cmp++;
        if (a_dbg_rdata !== 32'h0808_0808) begin
          n_bad++; $display("FAIL early_drop_data: got %h expected 08080808", a_dbg_rdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_contention();
    test_addr_checks();
    test_reset_midop();
    test_zero_wait();
    test_early_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
